// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: integer register file with bypassed reads and per-register pending-write scoreboard driving decode stall
module reg_file_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNTW  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            use_rs1,
  input  logic            use_rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wr,
  output logic            stall,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);
  logic [XLEN-1:0] regs [NREGS];
  logic [CNTW-1:0] cnt  [NREGS];
  logic            hit1, hit2, hitd, busy1, busy2, full, accept;
  always_comb begin
    hit1     = wb_en && wb_addr == rs1_addr;
    hit2     = wb_en && wb_addr == rs2_addr;
    hitd     = wb_en && wb_addr == issue_rd;
    rs1_data = rs1_addr == '0 ? '0 : hit1 ? wb_data : regs[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : hit2 ? wb_data : regs[rs2_addr];
    busy1    = use_rs1 && rs1_addr != '0 && cnt[rs1_addr] != '0 && !(cnt[rs1_addr] == CNTW'(1) && hit1);
    busy2    = use_rs2 && rs2_addr != '0 && cnt[rs2_addr] != '0 && !(cnt[rs2_addr] == CNTW'(1) && hit2);
    full     = issue_wr && issue_rd != '0 && cnt[issue_rd] == '1 && !hitd;
    stall    = issue_valid && (busy1 || busy2 || full);
    accept   = issue_valid && issue_wr && !stall;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
      for (int r = 1; r < NREGS; r++) begin
        if (accept && issue_rd == AW'(r) && !(wb_en && wb_addr == AW'(r) && cnt[r] != '0))
          cnt[r] <= cnt[r] + 1'b1;
        else if (wb_en && wb_addr == AW'(r) && cnt[r] != '0 && !(accept && issue_rd == AW'(r)))
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: randomized scoreboard bench against a behavioural register/pending model
module tb_reg_file_scoreboard;
  logic        clock = 0;
  logic        reset = 1;
  logic [4:0]  rs1_addr = 0, rs2_addr = 0, issue_rd = 0, wb_addr = 0;
  logic        use_rs1 = 0, use_rs2 = 0, issue_valid = 0, issue_wr = 0, wb_en = 0;
  logic [31:0] wb_data = 0;
  logic [31:0] rs1_data, rs2_data;
  logic        stall;
  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        st;
  } exp_t;
  exp_t        q[$];
  logic [31:0] mreg [32];
  int          mcnt [32];
  int          total = 0;
  int          bad = 0;
  reg_file_scoreboard dut (
    .clock(clock), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] mread(logic [4:0] a);
    if (a == 0) return 0;
    if (wb_en && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction
  function automatic logic mbusy(logic u, logic [4:0] a);
    return u && a != 0 && mcnt[a] > 0 && !(mcnt[a] == 1 && wb_en && wb_addr == a);
  endfunction
  task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                      input logic u1, input logic u2, input logic iv, input logic [4:0] rd,
                      input logic iw, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    logic full, acc, dec;
    reset = rst; rs1_addr = a1; rs2_addr = a2; use_rs1 = u1; use_rs2 = u2;
    issue_valid = iv; issue_rd = rd; issue_wr = iw; wb_en = we; wb_addr = wa; wb_data = wd;
    full = iw && rd != 0 && mcnt[rd] == 3 && !(we && wa == rd);
    e.r1 = mread(a1);
    e.r2 = mread(a2);
    e.st = iv && (mbusy(u1, a1) || mbusy(u2, a2) || full);
    q.push_back(e);
    @(posedge clock);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        mreg[r] = 0;
        mcnt[r] = 0;
      end
    end else begin
      acc = iv && iw && !e.st && rd != 0;
      dec = we && wa != 0 && mcnt[wa] > 0;
      if (we && wa != 0) mreg[wa] = wd;
      if (acc && !(dec && wa == rd)) mcnt[rd]++;
      if (dec && !(acc && wa == rd)) mcnt[wa]--;
    end
    #1;
  endtask
  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    step(0, a1, a2, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic issue(input logic [4:0] a1, input logic u1, input logic [4:0] rd,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    step(0, a1, 0, u1, 0, 1, rd, 1, we, wa, wd);
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total += 3;
      if (rs1_data !== e.r1) begin
        bad++;
        $display("FAIL rs1_data @%0t: got %h want %h", $time, rs1_data, e.r1);
      end
      if (rs2_data !== e.r2) begin
        bad++;
        $display("FAIL rs2_data @%0t: got %h want %h", $time, rs2_data, e.r2);
      end
      if (stall !== e.st) begin
        bad++;
        $display("FAIL stall @%0t: got %b want %b", $time, stall, e.st);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int r = 0; r < 32; r++) begin
      mreg[r] = 'x;
      mcnt[r] = 0;
    end
    @(posedge clock);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 5, 1, 1, 5, 32'h1111_1111);
    idle(5, 7);
    step(0, 5, 7, 0, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF);
    idle(5, 7);
    step(0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
    idle(0, 0);
    issue(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    step(0, 0, 3, 0, 1, 0, 0, 0, 1, 3, 32'hA5A5_A5A5);
    idle(3, 5);
    issue(0, 0, 4, 0, 0, 0);
    issue(4, 1, 8, 0, 0, 0);
    issue(4, 1, 8, 0, 0, 0);
    issue(4, 1, 8, 1, 4, 32'h55);
    issue(4, 1, 0, 0, 0, 0);
    repeat (3) issue(0, 0, 9, 0, 0, 0);
    issue(0, 0, 9, 0, 0, 0);
    issue(0, 0, 9, 1, 9, 32'h99);
    issue(0, 0, 9, 0, 0, 0);
    issue(9, 1, 0, 0, 0, 0);
    issue(0, 0, 6, 0, 0, 0);
    issue(0, 0, 6, 1, 6, 32'h66);
    issue(6, 1, 0, 0, 0, 0);
    issue(0, 0, 6, 0, 0, 0);
    step(1, 6, 9, 1, 1, 1, 6, 1, 1, 6, 32'h77);
    issue(6, 1, 9, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
    end
    @(posedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Consumer end of the write-back stage: accepts the selected write-back value (`wb`, destination, enable) and commits it to the architectural integer register file.
- Serves decode with two combinational read ports, same-cycle write-to-read bypass and a per-register pending-write scoreboard.
- Drives decode's stall when an operand or destination is still in flight.
- Sits between decode (read/issue side) and write-back (write side) of the five-stage pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register address width, equal to log2(NREGS).
- CNTW, 2, pending-write counter width per register; maximum in-flight writes per register is 2^CNTW-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1_addr  in  AW  source-1 register index from decode.
- rs2_addr  in  AW  source-2 register index from decode.
- use_rs1  in  1  decoded instruction reads rs1.
- use_rs2  in  1  decoded instruction reads rs2.
- rs1_data  out  XLEN  source-1 value (bypassed).
- rs2_data  out  XLEN  source-2 value (bypassed).
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_wr  in  1  issuing instruction will write issue_rd at write-back.
- stall  out  1  decode must hold; the issue is not accepted.
- wb_en  in  1  write-back commits this cycle.
- wb_addr  in  AW  write-back destination.
- wb_data  in  XLEN  write-back value from the write-back mux.

Behaviour:
- Reset, synchronous on the rising clock edge with reset=1:
  - all registers are cleared to 0;
  - all pending counters are cleared to 0.
  - rs*_data, stall: combinational outputs; with counters 0 and wb_en=0 they read 0 and stall=0.
  - Reset dominates issue and wb_en in the same cycle.
  - Reset mid-operation discards all in-flight pending state.
- Write:
  - At the rising edge, if wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
  - Writes to x0 are ignored.
- Read, combinational, zero latency:
  - If rsN_addr=0, rsN_data=0.
  - Else if wb_en=1 and wb_addr=rsN_addr, rsN_data=wb_data (bypass).
  - Else rsN_data=reg[rsN_addr].
- Pending counter cnt[r], for r!=0:
  - inc = issue_valid & issue_wr & !stall & (issue_rd==r).
  - dec = wb_en & (wb_addr==r) & (cnt[r]!=0).
  - Next cnt[r]: +1 if inc&!dec; -1 if dec&!inc; unchanged if both or neither.
  - cnt[0] is always 0.
  - wb_en to a register with cnt=0 is a legal architectural write with no counter change.
- busyN = use_rsN & rsN_addr!=0 & cnt[rsN_addr]!=0, with one exception: if cnt[rsN_addr]==1 and the same-cycle write-back targets it, busyN=0 (bypass resolves the operand).
- full = issue_wr & issue_rd!=0 & cnt[issue_rd]==2^CNTW-1 & !(same-cycle wb to issue_rd).
- stall = issue_valid & (busy1 | busy2 | full). stall=0 whenever issue_valid=0.
- No accepted issue ever wraps a counter; cnt never underflows.
- Simultaneous issue and write-back to the same register in one cycle: counter unchanged, data written.

Test Plan:
- Reset, then read x5/x7 -> rs1_data=0, rs2_data=0, stall=0; write x5=0xDEADBEEF at wb_en, next cycle read x5 -> 0xDEADBEEF.
- Write-back x0=0x12345678, read x0 -> 0.
- Issue with issue_wr=1, issue_rd=0 -> stall=0, no busy state created.
- Same-cycle bypass: wb_en=1, wb_addr=3, wb_data=0xA5A5A5A5, rs2_addr=3 -> rs2_data=0xA5A5A5A5 in that cycle.
- RAW hazard:
  - Issue rd=4 -> cnt[4]=1.
  - Next issue with use_rs1=1, rs1_addr=4 -> stall=1 each cycle.
  - In the wb cycle for x4=0x55: stall=0 and rs1_data=0x55.
  - Following cycle: cnt[4]=0.
- Saturation: three accepted issues to rd=9 without write-back -> cnt[9]=3; fourth issue to rd=9 -> stall=1. Same fourth issue with concurrent wb to x9 -> stall=0, cnt stays 3.
- Simultaneous issue rd=6 and wb x6 with cnt[6]=1 -> cnt[6]=1 after the edge, reg[6] updated. Assert reset with cnt[6]=2 -> cnt cleared, reg[6]=0, stall=0 next cycle.
